serdes_frame_packer: RTL and testbench
======================================

Name: serdes_frame_packer

Overview:
Upstream stage of the ECC serdes. It collects a variable-length payload from a producer stream and frames it as SOF word, length word, payload words, then checksum word. The framed words are presented on a valid/ready parallel interface that connects directly to the serdes parallel input (parallel_in_i / valid_in_i / ready_out_o). Payload is fully buffered before transmission so the length word is known up front.

Parameters:
DATA_WIDTH, 8, width of every word (payload, SOF, length, checksum).
MAX_LEN, 16, max payload words per frame; legal range 1..2^DATA_WIDTH-1.
SOF_WORD, 8'hA5 (zero-extended to DATA_WIDTH), start-of-frame marker.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
data_i  in  DATA_WIDTH  payload word from producer.
valid_i  in  1  producer word valid.
last_i  in  1  marks final payload word of frame; qualified by valid_i.
ready_o  out  1  packer accepts payload word.
parallel_out_o  out  DATA_WIDTH  framed word to serdes parallel_in_i.
valid_out_o  out  1  framed word valid, to serdes valid_in_i.
ready_in_i  in  1  serdes ready_out_o.
busy_o  out  1  high whenever state != COLLECT or payload count != 0.
trunc_o  out  1  one-cycle pulse when a frame is closed by MAX_LEN, not last_i.
frame_count_o  out  16  frames fully sent; wraps 0xFFFF->0.

Behaviour:
- Reset (rst_i=1 at clock edge): state=COLLECT, count=0, checksum=0, ready_o=0 during reset cycle then 1, valid_out_o=0, parallel_out_o=0, busy_o=0, trunc_o=0, frame_count_o=0. Reset mid-frame discards buffered payload and any in-flight word; nothing partial is resumed.
- Payload accept: transfer on valid_i && ready_o. Word written to buffer[count], count++, checksum ^= data_i.
- ready_o=1 only in COLLECT; 0 in all SEND states. No combinational path from ready_in_i to ready_o.
- Frame close: accepted word with last_i=1, or accepted word making count==MAX_LEN (trunc_o pulses next cycle if last_i=0). Next cycle state=SEND_SOF.
- States: COLLECT -> SEND_SOF -> SEND_LEN -> SEND_PAY -> SEND_CSUM -> COLLECT.
- Output words are registered. On entering each state, parallel_out_o loads the word and valid_out_o=1. The state advances only on valid_out_o && ready_in_i.
- SEND_SOF drives SOF_WORD. SEND_LEN drives count. SEND_PAY drives buffer[idx] for idx=0..count-1, advancing idx per handshake. SEND_CSUM drives the XOR of all payload words (length and SOF excluded).
- Latency: first SOF valid one cycle after the closing payload word is accepted. With ready_in_i held high, a frame of N payload words occupies N+3 consecutive valid cycles.
- Output stability: while valid_out_o=1 and ready_in_i=0, parallel_out_o and valid_out_o hold unchanged, regardless of how long the stall lasts.
- On the CSUM handshake: frame_count_o++, count/idx/checksum cleared, state=COLLECT. ready_o=1 the following cycle; valid_out_o=0 that cycle.
- No back-to-back overlap: the next frame cannot be collected until the current one is fully sent.
- Words accepted with valid_i=0 are ignored. last_i is ignored when valid_i=0.

Test Plan:
- Reset then payload {0x11,0x22,0x33} with last on 0x33, ready_in_i=1 -> output A5,03,11,22,33,00 on 6 consecutive valid cycles; frame_count_o=1; trunc_o never pulses.
- Single word 0x5A with last, ready_in_i=1 -> A5,01,5A,5A; ready_o returns high 1 cycle after the CSUM handshake.
- Sixteen words 0x00..0x0F, last_i never asserted (MAX_LEN=16) -> trunc_o pulses once; output A5,10,00..0F,00; ready_o=0 throughout the send.
- Frame {0xFF,0x01} with ready_in_i toggling 1,0,0,1,... -> parallel_out_o stable during every stall; exactly A5,02,FF,01,FE delivered, no duplicates or drops.
- rst_i asserted during SEND_PAY of a 4-word frame -> next cycle valid_out_o=0, frame_count_o=0; new frame {0x07} with last -> A5,01,07,07.
- Force frame_count_o to 0xFFFF (preload or 65535 frames), send one more frame -> frame_count_o=0x0000.

Source files
------------

// File: rtl/serdes_frame_packer.sv
// Buffers one payload frame and then emits it as SOF, length, payload and XOR checksum
// on a registered valid/ready stream feeding the serdes parallel input.
module serdes_frame_packer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF_WORD   = 'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    input  logic                  ready_in_i,
    output logic                  busy_o,
    output logic                  trunc_o,
    output logic [15:0]           frame_count_o
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {COLLECT, SEND_SOF, SEND_LEN, SEND_PAY, SEND_CSUM} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf [MAX_LEN];
    logic [CW-1:0]         r_count, r_idx;
    logic [DATA_WIDTH-1:0] r_csum;
    logic [DATA_WIDTH-1:0] r_out, w_out_nxt;
    logic                  r_vout, w_vout_nxt;
    logic                  r_trunc;
    logic [15:0]           r_frame_cnt;

    logic                  w_accept, w_hs, w_close, w_pay_last;
    logic [CW-1:0]         w_count_inc, w_idx_inc;

    assign ready_o        = (r_state == COLLECT) && !rst_i;
    assign w_accept       = valid_i && ready_o;
    assign w_hs           = r_vout && ready_in_i;
    assign w_count_inc    = r_count + 1'b1;
    assign w_idx_inc      = r_idx + 1'b1;
    assign w_close        = w_accept && (last_i || (w_count_inc == CW'(MAX_LEN)));
    assign w_pay_last     = (w_idx_inc == r_count);

    assign parallel_out_o = r_out;
    assign valid_out_o    = r_vout;
    assign busy_o         = (r_state != COLLECT) || (r_count != '0);
    assign trunc_o        = r_trunc;
    assign frame_count_o  = r_frame_cnt;

    // The next output word is chosen here so it is registered on the same edge the state moves.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_vout_nxt  = r_vout;
        case (r_state)
            COLLECT: begin
                if (w_close) begin
                    w_state_nxt = SEND_SOF;
                    w_out_nxt   = SOF_WORD;
                    w_vout_nxt  = 1'b1;
                end
            end
            SEND_SOF: begin
                if (w_hs) begin
                    w_state_nxt = SEND_LEN;
                    w_out_nxt   = DATA_WIDTH'(r_count);
                end
            end
            SEND_LEN: begin
                if (w_hs) begin
                    w_state_nxt = SEND_PAY;
                    w_out_nxt   = r_buf[0];
                end
            end
            SEND_PAY: begin
                if (w_hs) begin
                    if (w_pay_last) begin
                        w_state_nxt = SEND_CSUM;
                        w_out_nxt   = r_csum;
                    end else begin
                        w_out_nxt   = r_buf[w_idx_inc[IW-1:0]];
                    end
                end
            end
            SEND_CSUM: begin
                if (w_hs) begin
                    w_state_nxt = COLLECT;
                    w_out_nxt   = '0;
                    w_vout_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
                w_out_nxt   = '0;
                w_vout_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_out       <= '0;
            r_vout      <= 1'b0;
            r_trunc     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_vout  <= w_vout_nxt;
            r_trunc <= w_close && !last_i;
            if (w_accept) begin
                r_count <= w_count_inc;
                r_csum  <= r_csum ^ data_i;
            end
            if (r_state == SEND_PAY && w_hs)
                r_idx <= w_idx_inc;
            if (r_state == SEND_CSUM && w_hs) begin
                r_count     <= '0;
                r_idx       <= '0;
                r_csum      <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Payload storage needs no reset; count gates what is ever read back.
    always_ff @(posedge clk_i) begin
        if (w_accept)
            r_buf[r_count[IW-1:0]] <= data_i;
    end
endmodule

// File: tb/tb_serdes_frame_packer.sv
// Scoreboard bench for serdes_frame_packer: directed frames push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_serdes_frame_packer;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, last_i, ready_in;
    logic [7:0]  data_i;
    logic        ready_o, valid_out_o, busy_o, trunc_o;
    logic [7:0]  parallel_out_o;
    logic [15:0] frame_count_o;

    int          checks = 0, errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  pay[16];
    int          trunc_cnt = 0, vcnt = 0;
    bit          stall_mode = 1'b0;

    serdes_frame_packer dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .ready_o(ready_o), .parallel_out_o(parallel_out_o), .valid_out_o(valid_out_o),
        .ready_in_i(ready_in), .busy_o(busy_o), .trunc_o(trunc_o), .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    // Presents pay[0..n-1]; each word held until ready_o is seen, then accepted at the next edge.
    task automatic send_words(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            int t;
            data_i  = pay[i];
            valid_i = 1'b1;
            last_i  = use_last && (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!ready_o && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!ready_o) chk("accept_timeout", 32'd0, 32'd1);
            align();
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Returns at negedge+1 once the last expected word is on the bus with its handshake pending.
    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin : ready_drv
        bit [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode) begin
                ready_in = pat[k % 4];
                k++;
            end else begin
                ready_in = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic       pst;
        logic [7:0] pd;
        pst = 1'b0;
        pd  = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pst = 1'b0;
                continue;
            end
            if (pst) begin
                chk("stall_hold_valid", valid_out_o, 1);
                chk("stall_hold_data", parallel_out_o, pd);
            end
            if (valid_out_o) begin
                vcnt++;
                chk("ready_low_in_send", ready_o, 0);
            end
            if (trunc_o) trunc_cnt++;
            if (valid_out_o && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none", parallel_out_o);
                end else begin
                    chk("word", parallel_out_o, exp_q.pop_front());
                end
            end
            pst = valid_out_o && !ready_in;
            pd  = parallel_out_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_out_o, 0);
        chk("rst_data", parallel_out_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_trunc", trunc_o, 0);
        chk("rst_fcount", frame_count_o, 0);
        align();
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready_o, 1);
        align();

        // Idle cycles with last_i but no valid_i must be ignored.
        data_i = 8'hFF; last_i = 1'b1;
        align(); align();
        last_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        align();

        // Three-word frame.
        vcnt = 0; trunc_cnt = 0;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        send_words(3, 1'b1);
        chk("sof_latency_valid", valid_out_o, 1);
        chk("sof_latency_data", parallel_out_o, 8'hA5);
        wait_drain();
        @(negedge clk);
        chk("f1_valid_cycles", vcnt, 6);
        chk("f1_fcount", frame_count_o, 1);
        chk("f1_trunc", trunc_cnt, 0);
        align();

        // Single-word frame; ready_o back the cycle after the checksum handshake.
        pay[0] = 8'h5A;
        push(8'hA5); push(8'h01); push(8'h5A); push(8'h5A);
        send_words(1, 1'b1);
        wait_drain();
        @(negedge clk);
        chk("f2_ready_back", ready_o, 1);
        chk("f2_valid_drop", valid_out_o, 0);
        chk("f2_busy", busy_o, 0);
        chk("f2_fcount", frame_count_o, 2);
        align();

        // MAX_LEN truncation, no last_i.
        trunc_cnt = 0;
        push(8'hA5); push(8'h10);
        for (int i = 0; i < 16; i++) begin
            pay[i] = 8'(i);
            push(8'(i));
        end
        push(8'h00);
        send_words(16, 1'b0);
        wait_drain();
        @(negedge clk);
        chk("f3_trunc_pulses", trunc_cnt, 1);
        chk("f3_fcount", frame_count_o, 3);
        align();

        // Back-pressure with ready_in pattern 1,0,0,1.
        stall_mode = 1'b1;
        pay[0] = 8'hFF; pay[1] = 8'h01;
        push(8'hA5); push(8'h02); push(8'hFF); push(8'h01); push(8'hFE);
        send_words(2, 1'b1);
        wait_drain();
        @(negedge clk);
        stall_mode = 1'b0;
        chk("f4_fcount", frame_count_o, 4);
        align(); align();

        // Reset in the middle of the payload phase.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        push(8'hA5); push(8'h04); push(8'h01);
        send_words(4, 1'b1);
        wait_drain();
        rst_i = 1'b1;
        align();
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid_out_o, 0);
        chk("midrst_fcount", frame_count_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ready", ready_o, 1);
        align();
        pay[0] = 8'h07;
        push(8'hA5); push(8'h01); push(8'h07); push(8'h07);
        send_words(1, 1'b1);
        wait_drain();
        @(negedge clk);
        chk("f5_fcount", frame_count_o, 1);
        align();

        // Frame counter wrap from 0xFFFF.
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        #1;
        chk("preload_fcount", frame_count_o, 16'hFFFF);
        align();
        pay[0] = 8'h3C;
        push(8'hA5); push(8'h01); push(8'h3C); push(8'h3C);
        send_words(1, 1'b1);
        wait_drain();
        @(negedge clk);
        chk("wrap_fcount", frame_count_o, 16'h0000);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
